io_timer_irq_m: RTL and testbench

Memory-mapped timer and interrupt-flag block for the SM80 GameBoy core. It owns DIV, TIMA, TMA, TAC, IF (FF0F) and IE (FFFF). It sits behind the MMU's IO decode and directly feeds the CPU's `mmio_reg_IF` / `mmio_reg_IE` inputs. The CPU's interrupt-dispatch write to FF0F lands back in this block.

---
 rtl/io_timer_irq_m_pkg.sv | 39 +++
 rtl/io_timer_irq_m_timer_core.sv | 123 ++++++++++++
 rtl/io_timer_irq_m.sv | 110 +++++++++++
 tb/tb_io_timer_irq_m.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/io_timer_irq_m_pkg.sv
// Shared definitions for the SM80 timer / interrupt-flag IO block.
package io_defs;

    // IO register addresses owned by this block
    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;
    localparam logic [15:0] ADDR_IF   = 16'hFF0F;
    localparam logic [15:0] ADDR_IE   = 16'hFFFF;

    // Interrupt bit positions in IF / IE
    localparam int unsigned IRQ_VBLANK = 0;
    localparam int unsigned IRQ_STAT   = 1;
    localparam int unsigned IRQ_TIMER  = 2;
    localparam int unsigned IRQ_SERIAL = 3;
    localparam int unsigned IRQ_JOYPAD = 4;

    // Ticks spent with TIMA reading 00 between overflow and TMA reload
    localparam logic [2:0] RELOAD_TICKS = 3'd4;

    typedef enum logic {
        T_IDLE,
        T_RELOAD
    } timer_state_t;

    // Timer input: enable gated with the system-counter bit chosen by TAC[1:0]
    function automatic logic timer_input(input logic [15:0] sc, input logic [2:0] tac);
        logic bit_sel;
        case (tac[1:0])
            2'b00:   bit_sel = sc[9];
            2'b01:   bit_sel = sc[3];
            2'b10:   bit_sel = sc[5];
            default: bit_sel = sc[7];
        endcase
        return tac[2] & bit_sel;
    endfunction

endpackage

// File: rtl/io_timer_irq_m_timer_core.sv
// DIV/TIMA/TMA/TAC timer core: system counter, falling-edge detect and reload FSM.
module timer_core_m
    import io_defs::*;
#(
    parameter logic [15:0] DIV_RESET = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       we_div,
    input  logic       we_tima,
    input  logic       we_tma,
    input  logic       we_tac,
    input  logic [7:0] wdata,
    output logic [7:0] div_val,
    output logic [7:0] tima_val,
    output logic [7:0] tma_val,
    output logic [7:0] tac_val,
    output logic       timer_irq
);

    timer_state_t state_q, state_d;
    logic [15:0]  sc_q, sc_d;
    logic         tin_q;
    logic         tin;
    logic         tin_fall;
    logic [7:0]   tima_q, tima_d;
    logic [7:0]   tma_q, tma_d;
    logic [2:0]   tac_q, tac_d;
    logic [2:0]   cnt_q, cnt_d;

    // Timer input and its 1->0 transition against last cycle's value
    always_comb begin
        tin      = timer_input(sc_q, tac_q);
        tin_fall = tin_q & ~tin;
    end

    // Plain register next-state: DIV write clears the counter even without a tick
    always_comb begin
        if (we_div) begin
            sc_d = 16'h0000;
        end else if (tick) begin
            sc_d = sc_q + 16'd1;
        end else begin
            sc_d = sc_q;
        end
        tma_d = we_tma ? wdata : tma_q;
        tac_d = we_tac ? wdata[2:0] : tac_q;
    end

    // Reload FSM next-state; a CPU TIMA write always wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tima_d  = tima_q;
        case (state_q)
            T_IDLE: begin
                if (we_tima) begin
                    tima_d = wdata;
                end else if (tin_fall) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        cnt_d   = RELOAD_TICKS;
                        state_d = T_RELOAD;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            T_RELOAD: begin
                if (we_tima) begin
                    // Cancels the pending reload and its interrupt
                    tima_d  = wdata;
                    cnt_d   = 3'd0;
                    state_d = T_IDLE;
                end else if (tick) begin
                    if (cnt_q == 3'd1) begin
                        // Same-cycle TMA write is picked up here
                        tima_d  = tma_d;
                        cnt_d   = 3'd0;
                        state_d = T_IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = T_IDLE;
            end
        endcase
    end

    // State and register update; reset aborts any pending reload
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T_IDLE;
            sc_q    <= DIV_RESET;
            tin_q   <= 1'b0;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            tin_q   <= tin;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs: reload pulse coincides with the edge that loads TMA
    always_comb begin
        timer_irq = (state_q == T_RELOAD) && tick && (cnt_q == 3'd1) && !we_tima;
        tima_val  = (state_q == T_RELOAD) ? 8'h00 : tima_q;
        div_val   = sc_q[15:8];
        tma_val   = tma_q;
        tac_val   = {5'b11111, tac_q};
    end

endmodule

// File: rtl/io_timer_irq_m.sv
// Timer + IF/IE register block: address decode, read mux and interrupt flags.
module io_timer_irq_m
    import io_defs::*;
#(
    parameter logic [15:0] DIV_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        hit,
    input  logic [4:0]  irq_in,
    output logic [7:0]  reg_IF,
    output logic [7:0]  reg_IE
);

    logic       we_div;
    logic       we_tima;
    logic       we_tma;
    logic       we_tac;
    logic       we_if;
    logic       we_ie;
    logic [7:0] div_val;
    logic [7:0] tima_val;
    logic [7:0] tma_val;
    logic [7:0] tac_val;
    logic       timer_irq;
    logic [4:0] set_vec;
    logic [4:0] if_q, if_d;
    logic [7:0] ie_q, ie_d;

    // Write strobe decode
    always_comb begin
        we_div  = we && (addr == ADDR_DIV);
        we_tima = we && (addr == ADDR_TIMA);
        we_tma  = we && (addr == ADDR_TMA);
        we_tac  = we && (addr == ADDR_TAC);
        we_if   = we && (addr == ADDR_IF);
        we_ie   = we && (addr == ADDR_IE);
    end

    timer_core_m #(
        .DIV_RESET (DIV_RESET)
    ) u_timer_core (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .we_div    (we_div),
        .we_tima   (we_tima),
        .we_tma    (we_tma),
        .we_tac    (we_tac),
        .wdata     (wdata),
        .div_val   (div_val),
        .tima_val  (tima_val),
        .tma_val   (tma_val),
        .tac_val   (tac_val),
        .timer_irq (timer_irq)
    );

    // Set requests; the external timer bit is replaced by the internal reload pulse
    always_comb begin
        set_vec            = irq_in;
        set_vec[IRQ_TIMER] = timer_irq;
    end

    // Flag next-state: a set request beats a same-cycle clear
    always_comb begin
        if_d = (we_if ? wdata[4:0] : if_q) | set_vec;
        ie_d = we_ie ? wdata : ie_q;
    end

    // IF / IE registers
    always_ff @(posedge clk) begin
        if (rst) begin
            if_q <= 5'b00000;
            ie_q <= 8'h00;
        end else begin
            if_q <= if_d;
            ie_q <= ie_d;
        end
    end

    // CPU-facing register views
    always_comb begin
        reg_IF = {3'b111, if_q};
        reg_IE = ie_q;
    end

    // Zero-latency read mux
    always_comb begin
        rdata = 8'hFF;
        hit   = 1'b1;
        case (addr)
            ADDR_DIV:  rdata = div_val;
            ADDR_TIMA: rdata = tima_val;
            ADDR_TMA:  rdata = tma_val;
            ADDR_TAC:  rdata = tac_val;
            ADDR_IF:   rdata = reg_IF;
            ADDR_IE:   rdata = reg_IE;
            default: begin
                rdata = 8'hFF;
                hit   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_io_timer_irq_m.sv
// Directed self-checking bench for io_timer_irq_m.
module tb_io_timer_irq_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        hit;
    logic [4:0]  irq_in;
    logic [7:0]  reg_IF;
    logic [7:0]  reg_IE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_timer_irq_m #(
        .DIV_RESET (16'h0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
        .rdata  (rdata),
        .hit    (hit),
        .irq_in (irq_in),
        .reg_IF (reg_IF),
        .reg_IE (reg_IE)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the following rising edge
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check_eq(tag, {8'h00, rdata}, {8'h00, exp});
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // TAC=05 (sc[3]), TMA=80, TIMA=FE, sc cleared; ticking starts on the next edge
    task automatic setup_overflow;
        tick = 1'b0;
        wr(16'hFF07, 8'h05);
        wr(16'hFF06, 8'h80);
        wr(16'hFF05, 8'hFE);
        wr(16'hFF04, 8'h00);
        tick = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        tick   = 1'b0;
        addr   = 16'h0000;
        we     = 1'b0;
        wdata  = 8'h00;
        irq_in = 5'b00000;
        wait_clk(2);
        rst = 1'b0;

        // Reset values
        check_eq("rst_if", {8'h00, reg_IF}, 16'h00E0);
        check_eq("rst_ie", {8'h00, reg_IE}, 16'h0000);
        rd_check("rst_div", 16'hFF04, 8'h00);
        rd_check("rst_tima", 16'hFF05, 8'h00);
        rd_check("rst_tac", 16'hFF07, 8'hF8);
        check_eq("rst_hit", {15'h0, hit}, 16'h0001);

        // Overflow, 4-tick reload, IRQ
        setup_overflow();
        wait_clk(16);
        rd_check("ovf_t16", 16'hFF05, 8'hFE);
        wait_clk(1);
        rd_check("ovf_t17", 16'hFF05, 8'hFF);
        wait_clk(15);
        rd_check("ovf_t32", 16'hFF05, 8'hFF);
        wait_clk(1);
        rd_check("ovf_t33", 16'hFF05, 8'h00);
        check_eq("ovf_if33", {8'h00, reg_IF}, 16'h00E0);
        wait_clk(3);
        rd_check("ovf_t36", 16'hFF05, 8'h00);
        check_eq("ovf_if36", {8'h00, reg_IF}, 16'h00E0);
        wait_clk(1);
        rd_check("ovf_t37", 16'hFF05, 8'h80);
        check_eq("ovf_if37", {8'h00, reg_IF}, 16'h00E4);
        rd_check("ovf_rd_if", 16'hFF0F, 8'hE4);

        // TIMA write during reload cancels it
        tick = 1'b0;
        do_reset();
        setup_overflow();
        wait_clk(33);
        rd_check("cancel_t33", 16'hFF05, 8'h00);
        wr(16'hFF05, 8'h33);
        rd_check("cancel_tima", 16'hFF05, 8'h33);
        wait_clk(4);
        rd_check("cancel_tima_late", 16'hFF05, 8'h33);
        check_eq("cancel_if", {8'h00, reg_IF}, 16'h00E0);

        // DIV write causes one spurious increment when the selected bit falls
        tick = 1'b0;
        do_reset();
        tick = 1'b1;
        wait_clk(512);
        tick = 1'b0;
        rd_check("div_0200", 16'hFF04, 8'h02);
        wr(16'hFF07, 8'h04);
        wr(16'hFF05, 8'h10);
        rd_check("div_tima_pre", 16'hFF05, 8'h10);
        wr(16'hFF04, 8'hAB);
        rd_check("div_cleared", 16'hFF04, 8'h00);
        rd_check("div_tima_lat", 16'hFF05, 8'h10);
        wait_clk(1);
        rd_check("div_tima_inc", 16'hFF05, 8'h11);
        wait_clk(3);
        rd_check("div_tima_once", 16'hFF05, 8'h11);

        // IF set/clear priority
        irq_in = 5'b00010;
        @(negedge clk);
        irq_in = 5'b00000;
        check_eq("if_stat", {8'h00, reg_IF}, 16'h00E2);
        irq_in = 5'b00001;
        wr(16'hFF0F, 8'h00);
        irq_in = 5'b00000;
        check_eq("if_set_wins", {8'h00, reg_IF}, 16'h00E1);
        irq_in = 5'b00100;
        @(negedge clk);
        irq_in = 5'b00000;
        check_eq("if_bit2_ignored", {8'h00, reg_IF}, 16'h00E1);
        wr(16'hFF0F, 8'h1F);
        rd_check("if_write_all", 16'hFF0F, 8'hFF);
        wr(16'hFF0F, 8'h00);
        check_eq("if_clear", {8'h00, reg_IF}, 16'h00E0);

        // Plain registers and decode
        wr(16'hFFFF, 8'h1F);
        rd_check("ie_rd", 16'hFFFF, 8'h1F);
        check_eq("ie_hit", {15'h0, hit}, 16'h0001);
        check_eq("ie_port", {8'h00, reg_IE}, 16'h001F);
        wr(16'hFF07, 8'hFF);
        rd_check("tac_rd", 16'hFF07, 8'hFF);
        wr(16'hFF06, 8'h5A);
        rd_check("tma_rd", 16'hFF06, 8'h5A);
        rd_check("miss_rd", 16'hFF10, 8'hFF);
        check_eq("miss_hit", {15'h0, hit}, 16'h0000);

        // Reset mid-reload
        tick = 1'b0;
        do_reset();
        setup_overflow();
        wait_clk(34);
        rd_check("rr_in_reload", 16'hFF05, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_check("rr_tima", 16'hFF05, 8'h00);
        rd_check("rr_tma", 16'hFF06, 8'h00);
        rd_check("rr_tac", 16'hFF07, 8'hF8);
        check_eq("rr_if", {8'h00, reg_IF}, 16'h00E0);
        check_eq("rr_ie", {8'h00, reg_IE}, 16'h0000);
        wait_clk(6);
        check_eq("rr_if_late", {8'h00, reg_IF}, 16'h00E0);
        rd_check("rr_tima_late", 16'hFF05, 8'h00);
        rd_check("rr_div_late", 16'hFF04, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
